present_sp_iter: RTL and testbench

- Iterative, parametrised PRESENT-style round engine.
- Each round XORs an externally supplied round key, then applies the substitution/permutation layers: forward for encryption, inverse for decryption.
- After NROUNDS rounds it applies a final whitening key XOR.
- Sits between the key-schedule unit, which supplies keys on request, and the cipher top. Valid/ready handshake on both data sides.

---
 rtl/present_pkg.sv | 40 ++++
 rtl/present_sp_layer.sv | 35 +++
 rtl/present_sp_iter.sv | 109 ++++++++++
 tb/tb_present_sp_iter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// present_pkg: shared definitions for the iterative PRESENT-style round engine.
//   - SBOX / SBOX_INV : 4-bit substitution table and its inverse
//   - state_e         : round engine FSM states
//   - perm_fwd/inv    : destination bit index of the bit permutation and its inverse
//   - ENC / DEC       : encodings of the mode input
package present_pkg;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Bit i moves to i*width/4 mod (width-1); the top bit maps onto itself.
  function automatic int perm_fwd(input int i, input int width);
    if (i == width - 1) return i;
    return (i * (width / 4)) % (width - 1);
  endfunction

  // Undoes perm_fwd: 4*(i*width/4) = i*width, which is i mod (width-1).
  function automatic int perm_inv(input int i, input int width);
    if (i == width - 1) return i;
    return (4 * i) % (width - 1);
  endfunction

endpackage

// File: rtl/present_sp_layer.sv
// present_sp_layer: combinational substitution/permutation layer.
//   mode_i  : ENC -> P(S(x)), DEC -> S^-1(P^-1(x))
//   data_i  : WIDTH-bit layer input (state already XORed with the round key)
//   data_o  : WIDTH-bit layer output
module present_sp_layer
  import present_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] sub_fwd;
  logic [WIDTH-1:0] enc_val;
  logic [WIDTH-1:0] perm_back;
  logic [WIDTH-1:0] dec_val;

  for (genvar n = 0; n < WIDTH / 4; n++) begin : g_nib
    assign sub_fwd[4*n +: 4] = SBOX[data_i[4*n +: 4]];
    assign dec_val[4*n +: 4] = SBOX_INV[perm_back[4*n +: 4]];
  end

  // Permutations are pure wiring; indices resolve at elaboration.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    localparam int FWD = perm_fwd(b, WIDTH);
    localparam int INV = perm_inv(b, WIDTH);
    assign enc_val[FWD]   = sub_fwd[b];
    assign perm_back[INV] = data_i[b];
  end

  assign data_o = (mode_i == DEC) ? dec_val : enc_val;

endmodule

// File: rtl/present_sp_iter.sv
// present_sp_iter: iterative PRESENT-style round engine, one round per clock.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : input block handshake, mode_i/data_i sampled on accept
//   key_req_o, rnd_o, rk_i: round-key request; rk_i must be valid while key_req_o=1
//   out_valid_o/out_ready_i, data_o : result handshake, data_o held while valid
module present_sp_iter
  import present_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NROUNDS = 31
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         mode_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic                         key_req_o,
  output logic [$clog2(NROUNDS+1)-1:0] rnd_o,
  input  logic [WIDTH-1:0]             rk_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             data_o
);

  localparam int RW = $clog2(NROUNDS + 1);
  localparam logic [RW-1:0] LAST_RND = RW'(NROUNDS - 1);

  if ((WIDTH % 4 != 0) || (WIDTH < 16)) begin : g_bad_width
    $error("present_sp_iter: WIDTH must be a multiple of 4 and at least 16");
  end
  if (NROUNDS < 1) begin : g_bad_rounds
    $error("present_sp_iter: NROUNDS must be at least 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             mode_q,  mode_d;
  logic [RW-1:0]    rnd_q,   rnd_d;

  logic [WIDTH-1:0] layer_in;
  logic [WIDTH-1:0] layer_out;

  assign layer_in = data_q ^ rk_i;

  present_sp_layer #(.WIDTH(WIDTH)) u_layer (
    .mode_i (mode_q),
    .data_i (layer_in),
    .data_o (layer_out)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    rnd_d       = rnd_q;
    in_ready_o  = 1'b0;
    key_req_o   = 1'b0;
    out_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: in_ready_o = 1'b1;
      ST_RUN: begin
        key_req_o = 1'b1;
        data_d    = layer_out;
        rnd_d     = rnd_q + 1'b1;
        if (rnd_q == LAST_RND) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        key_req_o = 1'b1;
        data_d    = layer_in;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        // Result leaving frees the engine in the same cycle for the next block.
        in_ready_o  = out_ready_i;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the DONE->IDLE return when a block is waiting.
    if (in_ready_o && in_valid_i) begin
      data_d  = data_i;
      mode_d  = mode_i;
      rnd_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mode_q  <= ENC;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rnd_q   <= rnd_d;
    end
  end

  assign rnd_o  = rnd_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_present_sp_iter.sv
// Bench for present_sp_iter: three instances (64/31, 64/1, 16/4) checked against
// hand-derived constants, the PRESENT-80 known answer and a behavioural model.
module tb_present_sp_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: defaults
  logic        a_in_valid, a_in_ready, a_mode, a_key_req, a_out_valid, a_out_ready;
  logic [63:0] a_data, a_rk, a_dout;
  logic [4:0]  a_rnd;
  logic [63:0] a_keys [32];
  assign a_rk = a_keys[a_rnd];

  // Instance B: one round
  logic        b_in_valid, b_in_ready, b_mode, b_key_req, b_out_valid, b_out_ready;
  logic [63:0] b_data, b_rk, b_dout;
  logic [0:0]  b_rnd;
  logic [63:0] b_keys [2];
  assign b_rk = b_keys[b_rnd];

  // Instance C: 16-bit, four rounds
  logic        c_in_valid, c_in_ready, c_mode, c_key_req, c_out_valid, c_out_ready;
  logic [15:0] c_data, c_rk, c_dout;
  logic [2:0]  c_rnd;
  logic [15:0] c_keys [8];
  assign c_rk = c_keys[c_rnd];

  present_sp_iter u_a (
    .clk(clk), .rst(rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .mode_i(a_mode), .data_i(a_data), .key_req_o(a_key_req), .rnd_o(a_rnd),
    .rk_i(a_rk), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .data_o(a_dout));

  present_sp_iter #(.WIDTH(64), .NROUNDS(1)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .mode_i(b_mode), .data_i(b_data), .key_req_o(b_key_req), .rnd_o(b_rnd),
    .rk_i(b_rk), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .data_o(b_dout));

  present_sp_iter #(.WIDTH(16), .NROUNDS(4)) u_c (
    .clk(clk), .rst(rst), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .mode_i(c_mode), .data_i(c_data), .key_req_o(c_key_req), .rnd_o(c_rnd),
    .rk_i(c_rk), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .data_o(c_dout));

  // ---------------- reference model ----------------
  localparam logic [3:0] M_SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [63:0] m_layer(input logic [63:0] x, input int w, input bit dec);
    logic [63:0] t = '0;
    logic [63:0] r = '0;
    if (!dec) begin
      for (int n = 0; n < w / 4; n++) t[4*n +: 4] = M_SB[x[4*n +: 4]];
      for (int i = 0; i < w; i++) r[(i == w - 1) ? i : (i * (w / 4)) % (w - 1)] = t[i];
    end else begin
      for (int i = 0; i < w; i++) t[(i == w - 1) ? i : (4 * i) % (w - 1)] = x[i];
      for (int n = 0; n < w / 4; n++)
        for (int v = 0; v < 16; v++)
          if (M_SB[v] == t[4*n +: 4]) r[4*n +: 4] = 4'(v);
    end
    return r;
  endfunction

  function automatic logic [63:0] m_cipher(input logic [63:0] x, input logic [63:0] k [32],
                                           input int nr, input int w, input bit dec);
    for (int r = 0; r < nr; r++) x = m_layer(x ^ k[r], w, dec);
    return x ^ k[nr];
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic a_send(input logic m, input logic [63:0] d);
    int t = 0;
    a_mode = m; a_data = d; a_in_valid = 1'b1;
    while (!a_in_ready && t < 100) begin step(); t++; end
    if (!a_in_ready) chk("a_accept_timeout", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0; a_data = {$urandom, $urandom}; a_mode = ~m;
  endtask

  task automatic a_wait(output logic [63:0] res, output int lat);
    lat = 0;
    while (!a_out_valid && lat < 200) begin step(); lat++; end
    res = a_dout;
  endtask

  task automatic a_take();
    a_out_ready = 1'b1; step(); a_out_ready = 1'b0;
  endtask

  task automatic run_a(input logic m, input logic [63:0] d, output logic [63:0] res, output int lat);
    a_send(m, d); a_wait(res, lat); a_take();
  endtask

  task automatic run_b(input logic m, input logic [63:0] d, output logic [63:0] res, output int lat);
    int t = 0;
    b_mode = m; b_data = d; b_in_valid = 1'b1;
    while (!b_in_ready && t < 100) begin step(); t++; end
    step();
    b_in_valid = 1'b0; b_data = {$urandom, $urandom}; b_mode = ~m;
    lat = 0;
    while (!b_out_valid && lat < 200) begin step(); lat++; end
    res = b_dout;
    b_out_ready = 1'b1; step(); b_out_ready = 1'b0;
  endtask

  task automatic run_c(input logic m, input logic [15:0] d, output logic [15:0] res, output int lat);
    int t = 0;
    c_mode = m; c_data = d; c_in_valid = 1'b1;
    while (!c_in_ready && t < 100) begin step(); t++; end
    step();
    c_in_valid = 1'b0; c_data = 16'($urandom); c_mode = ~m;
    lat = 0;
    while (!c_out_valid && lat < 200) begin step(); lat++; end
    res = c_dout;
    c_out_ready = 1'b1; step(); c_out_ready = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic [63:0] din;
    logic [63:0] k0;
    logic [63:0] k1;
    logic [63:0] exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [10];
    logic [63:0] kk [32];
    logic [63:0] pk [33];
    logic [79:0] kr;
    logic [63:0] res, res2, d1, d2, exp;
    logic [15:0] cres, cres2, cd;
    logic        m, seen;
    int          lat, t;

    a_in_valid = 0; a_out_ready = 0; a_mode = 0; a_data = '0;
    b_in_valid = 0; b_out_ready = 0; b_mode = 0; b_data = '0;
    c_in_valid = 0; c_out_ready = 0; c_mode = 0; c_data = '0;
    for (int i = 0; i < 32; i++) begin a_keys[i] = '0; kk[i] = '0; end
    b_keys[0] = '0; b_keys[1] = '0;
    for (int i = 0; i < 8; i++) c_keys[i] = '0;

    // One-round vectors: hand-derived constants, then model-derived random ones.
    tbl[0] = '{1'b0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFF00000000};
    tbl[1] = '{1'b1, 64'hFFFFFFFF00000000, 64'h0, 64'h0, 64'h0};
    tbl[2] = '{1'b0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF};
    tbl[3] = '{1'b1, 64'h0, 64'h0, 64'h0, 64'h5555555555555555};
    tbl[4] = '{1'b0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h00000000FFFF0000};
    tbl[5] = '{1'b1, 64'h00000000FFFF0000, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF};
    for (int i = 6; i < 10; i++) begin
      tbl[i].mode = 1'($urandom);
      tbl[i].din  = {$urandom, $urandom};
      tbl[i].k0   = {$urandom, $urandom};
      tbl[i].k1   = {$urandom, $urandom};
      kk[0] = tbl[i].k0; kk[1] = tbl[i].k1;
      tbl[i].exp  = m_cipher(tbl[i].din, kk, 1, 64, tbl[i].mode);
    end

    // PRESENT-80 key schedule, user key 0: pk[r] is round key K(r).
    kr = '0;
    for (int r = 1; r <= 32; r++) begin
      pk[r] = kr[79:16];
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = M_SB[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    pk[0] = '0;

    repeat (3) step();
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_key_req", 64'(a_key_req), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_rnd", 64'(a_rnd), 64'd0);
    chk("rst_data_o", a_dout, 64'd0);
    chk("rst_c_in_ready", 64'(c_in_ready), 64'd1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      b_keys[0] = tbl[i].k0; b_keys[1] = tbl[i].k1;
      run_b(tbl[i].mode, tbl[i].din, res, lat);
      chk($sformatf("tbl%0d_data", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd2);
    end

    // Known answer at defaults, then decrypt with reversed key order.
    for (int k = 0; k < 32; k++) a_keys[k] = pk[k+1];
    run_a(1'b0, 64'h0, res, lat);
    chk("kat_enc", res, 64'h5579C1387B228445);
    chk("kat_latency", 64'(lat), 64'd32);
    for (int k = 0; k < 32; k++) a_keys[k] = pk[32-k];
    run_a(1'b1, 64'h5579C1387B228445, res, lat);
    chk("kat_dec", res, 64'h0);

    // Back-pressure hold, then same-cycle hand-off to a new block.
    for (int k = 0; k < 32; k++) begin a_keys[k] = {$urandom, $urandom}; kk[k] = a_keys[k]; end
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    a_send(1'b0, d1);
    a_wait(res, lat);
    chk("hold_first_data", res, m_cipher(d1, kk, 31, 64, 1'b0));
    chk("hold_first_latency", 64'(lat), 64'd32);
    a_in_valid = 1'b1; a_data = d2; a_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_out_valid", 64'(a_out_valid), 64'd1);
      chk("hold_data_stable", a_dout, res);
      chk("hold_in_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    #1;
    chk("handoff_in_ready", 64'(a_in_ready), 64'd1);
    step();
    a_out_ready = 1'b0; a_in_valid = 1'b0; a_data = {$urandom, $urandom}; a_mode = 1'b0;
    a_wait(res2, lat);
    chk("handoff_latency", 64'(lat), 64'd32);
    chk("handoff_data", res2, m_cipher(d2, kk, 31, 64, 1'b1));
    a_take();

    // Reset in the middle of a block.
    d1 = {$urandom, $urandom};
    a_send(1'b0, d1);
    t = 0;
    while (a_rnd != 5'd15 && t < 100) begin step(); t++; end
    chk("mid_rst_reached_rnd15", 64'(a_rnd), 64'd15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("mid_rst_key_req", 64'(a_key_req), 64'd0);
    chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_rnd", 64'(a_rnd), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin step(); seen |= a_out_valid; end
    chk("mid_rst_no_output", 64'(seen), 64'd0);
    run_a(1'b0, d1, res, lat);
    chk("after_rst_data", res, m_cipher(d1, kk, 31, 64, 1'b0));

    // Small configuration: random blocks in both modes plus round trips.
    for (int it = 0; it < 100; it++) begin
      m = 1'($urandom);
      for (int k = 0; k < 32; k++) kk[k] = '0;
      for (int k = 0; k <= 4; k++) begin c_keys[k] = 16'($urandom); kk[k] = 64'(c_keys[k]); end
      cd = 16'($urandom);
      exp = m_cipher(64'(cd), kk, 4, 16, m);
      run_c(m, cd, cres, lat);
      chk($sformatf("c_rand%0d_mode%0d", it, m), 64'(cres), exp);
      chk("c_latency", 64'(lat), 64'd5);
      if (m == 1'b0) begin
        for (int k = 0; k <= 4; k++) c_keys[k] = kk[4-k][15:0];
        run_c(1'b1, cres, cres2, lat);
        chk($sformatf("c_roundtrip%0d", it), 64'(cres2), 64'(cd));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
